// File: rtl/dff_share_arb.sv
// dff_share_arb: round-robin arbiter/sequencer sharing one external WIDTH-bit register among NREQ requesters.
// Optional grant-hold feature enabled by defining DFF_ARB_LOCK_EN (adds the lock port).
module dff_share_arb #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
`ifdef DFF_ARB_LOCK_EN
    input  logic [NREQ-1:0]       lock,
`endif
    output logic [NREQ-1:0]       gnt,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [WIDTH-1:0]      rsp_q,
    output logic [WIDTH-1:0]      dff_d,
    output logic                  dff_en,
    input  logic [WIDTH-1:0]      dff_q,
    output logic                  busy
);
    localparam int PW = $clog2(NREQ);
    localparam logic [PW-1:0] LAST_IDX = PW'(NREQ - 1);
    localparam logic [PW:0]   NREQ_W   = (PW+1)'(NREQ);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   ptr_r;
    logic [PW-1:0]   win_r;
    logic [NREQ-1:0] gnt_r;
    logic [NREQ-1:0] rsp_valid_r;
    logic [WIDTH-1:0] rsp_q_r;
    logic [WIDTH-1:0] dff_d_r;
    logic            dff_en_r;

    logic [PW-1:0]   rr_win_s;
    logic [PW-1:0]   sel_s;
    logic [PW-1:0]   ptr_next_s;
    logic            hold_s;
    logic            decide_s;

    function automatic logic [NREQ-1:0] onehot(input logic [PW-1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    // Round-robin search from ptr upward; scanning farthest-first lets the nearest set bit win.
    always_comb begin
        logic [PW:0] cand;
        rr_win_s = ptr_r;
        cand     = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            cand = {1'b0, ptr_r} + (PW+1)'(i);
            if (cand >= NREQ_W) begin
                cand = cand - NREQ_W;
            end else begin
                cand = cand;
            end
            if (req[cand[PW-1:0]]) begin
                rr_win_s = cand[PW-1:0];
            end else begin
                rr_win_s = rr_win_s;
            end
        end
    end

    // Winner selection, lock hold and next-pointer computation.
    always_comb begin
`ifdef DFF_ARB_LOCK_EN
        hold_s = (state_r == RESP) && lock[win_r] && req[win_r];
`else
        hold_s = 1'b0;
`endif
        decide_s = ((state_r == IDLE) || (state_r == RESP)) && (|req);
        if (hold_s) begin
            sel_s = win_r;
        end else begin
            sel_s = rr_win_s;
        end
        if (sel_s == LAST_IDX) begin
            ptr_next_s = '0;
        end else begin
            ptr_next_s = sel_s + PW'(1);
        end
    end

    // Sequencer FSM; every output is registered on the edge entering the state that shows it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= IDLE;
            ptr_r       <= '0;
            win_r       <= '0;
            gnt_r       <= '0;
            rsp_valid_r <= '0;
            rsp_q_r     <= '0;
            dff_d_r     <= '0;
            dff_en_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE, RESP: begin
                    rsp_valid_r <= '0;
                    if (decide_s) begin
                        state_r  <= DRIVE;
                        win_r    <= sel_s;
                        gnt_r    <= onehot(sel_s);
                        dff_en_r <= 1'b1;
                        dff_d_r  <= wdata[sel_s*WIDTH +: WIDTH];
                        if (hold_s) begin
                            ptr_r <= ptr_r;
                        end else begin
                            ptr_r <= ptr_next_s;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                DRIVE: begin
                    state_r  <= WAIT;
                    gnt_r    <= '0;
                    dff_en_r <= 1'b0;
                end
                WAIT: begin
                    state_r     <= RESP;
                    rsp_q_r     <= dff_q;
                    rsp_valid_r <= onehot(win_r);
                end
                default: begin
                    state_r     <= IDLE;
                    gnt_r       <= '0;
                    rsp_valid_r <= '0;
                    dff_en_r    <= 1'b0;
                end
            endcase
        end
    end

    assign gnt       = gnt_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_q     = rsp_q_r;
    assign dff_d     = dff_d_r;
    assign dff_en    = dff_en_r;
    assign busy      = (state_r != IDLE);

endmodule

// File: tb/tb_dff_share_arb.sv
// tb_dff_share_arb: directed scenario tasks plus a randomized run against a transaction-level model.
module tb_dff_share_arb;
    localparam int NREQ  = 4;
    localparam int WIDTH = 1;
    localparam int NCYC  = 300;
    localparam int NARR  = NCYC + 4;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic [3:0] req   = 4'b0000;
    logic [3:0] wdata = 4'b0000;
`ifdef DFF_ARB_LOCK_EN
    logic [3:0] lock  = 4'b0000;
`endif
    logic [3:0] gnt;
    logic [3:0] rsp_valid;
    logic [0:0] rsp_q;
    logic [0:0] dff_d;
    logic       dff_en;
    logic [0:0] dff_q = 1'b0;
    logic       busy;

    int checks   = 0;
    int failures = 0;

    dff_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .wdata(wdata),
`ifdef DFF_ARB_LOCK_EN
        .lock(lock),
`endif
        .gnt(gnt),
        .rsp_valid(rsp_valid),
        .rsp_q(rsp_q),
        .dff_d(dff_d),
        .dff_en(dff_en),
        .dff_q(dff_q),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // External shared flip-flop.
    always @(posedge clk) begin
        if (dff_en) dff_q <= dff_d;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst   = 1'b0;
        req   = 4'b0000;
        wdata = 4'b0000;
`ifdef DFF_ARB_LOCK_EN
        lock  = 4'b0000;
`endif
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 5; c++) begin
            req   = (c == 0) ? 4'b0010 : ((c == 4) ? 4'b1111 : 4'b0000);
            wdata = (c == 0) ? 4'b0010 : ((c == 4) ? 4'b1111 : 4'b0000);
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({gnt, rsp_valid, rsp_q, dff_d, dff_en, busy} !== 12'b0) begin
            failures++;
            $display("FAIL reset_outputs got gnt=%b rsp=%b q=%b d=%b en=%b busy=%b exp all 0",
                     gnt, rsp_valid, rsp_q, dff_d, dff_en, busy);
        end
        req = 4'b0000;
        tick();
        tick();
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++;
            if ({busy, dff_en, gnt} !== 6'b0) begin
                failures++;
                $display("FAIL reset_release_idle cyc=%0d got busy=%b en=%b gnt=%b exp 0", c, busy, dff_en, gnt);
            end
            tick();
        end
    endtask

    task automatic test_single();
        req   = 4'b0100;
        wdata = 4'b0100;
        tick();
        req   = 4'b0000;
        wdata = 4'b0000;
        @(negedge clk);
        checks++;
        if ({gnt, dff_en, dff_d, busy} !== 7'b0100_1_1_1) begin
            failures++;
            $display("FAIL single_drive got gnt=%b en=%b d=%b busy=%b exp 0100 1 1 1", gnt, dff_en, dff_d, busy);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({gnt, dff_en, rsp_valid} !== 9'b0) begin
            failures++;
            $display("FAIL single_wait got gnt=%b en=%b rsp=%b exp 0", gnt, dff_en, rsp_valid);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_q} !== 5'b0100_1) begin
            failures++;
            $display("FAIL single_resp got rsp=%b q=%b exp 0100 1", rsp_valid, rsp_q);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({rsp_valid, rsp_q, busy} !== 6'b0000_1_0) begin
            failures++;
            $display("FAIL single_after got rsp=%b q=%b busy=%b exp 0000 1 0", rsp_valid, rsp_q, busy);
        end
        tick();
    endtask

    task automatic test_fairness();
        logic [3:0] wd_hist [0:15];
        logic [3:0] e;
        int w;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            wd_hist[c] = 4'($urandom_range(0, 15));
            wdata = wd_hist[c];
            req   = (c <= 12) ? 4'b1111 : 4'b0000;
            @(negedge clk);
            if (c % 3 == 1) begin
                w = ((c - 1) / 3) % 4;
                e = 4'b0001 << w;
                checks++;
                if (gnt !== e || dff_d !== wd_hist[c-1][w]) begin
                    failures++;
                    $display("FAIL fair_gnt cyc=%0d got gnt=%b d=%b exp gnt=%b d=%b", c, gnt, dff_d, e, wd_hist[c-1][w]);
                end
            end else begin
                checks++;
                if (gnt !== 4'b0000) begin
                    failures++;
                    $display("FAIL fair_gnt_idle cyc=%0d got %b exp 0000", c, gnt);
                end
            end
            if (c % 3 == 0 && c >= 3) begin
                w = (c / 3 - 1) % 4;
                e = 4'b0001 << w;
                checks++;
                if (rsp_valid !== e || rsp_q !== wd_hist[c-3][w]) begin
                    failures++;
                    $display("FAIL fair_rsp cyc=%0d got rsp=%b q=%b exp rsp=%b q=%b", c, rsp_valid, rsp_q, e, wd_hist[c-3][w]);
                end
            end else begin
                checks++;
                if (rsp_valid !== 4'b0000) begin
                    failures++;
                    $display("FAIL fair_rsp_idle cyc=%0d got %b exp 0000", c, rsp_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_wrap();
        for (int c = 0; c < 7; c++) begin
            req = (c == 0) ? 4'b1000 : ((c <= 3) ? 4'b1001 : 4'b0000);
            @(negedge clk);
            if (c == 1) begin
                checks++;
                if (gnt !== 4'b1000) begin
                    failures++;
                    $display("FAIL wrap_first got %b exp 1000", gnt);
                end
            end else if (c == 4) begin
                checks++;
                if (gnt !== 4'b0001) begin
                    failures++;
                    $display("FAIL wrap_second got %b exp 0001", gnt);
                end
            end
            tick();
        end
    endtask

    task automatic test_reset_mid();
        req = 4'b1111;
        tick();
        req = 4'b0000;
        @(negedge clk);
        checks++;
        if (gnt !== 4'b0010) begin
            failures++;
            $display("FAIL rstmid_pre_gnt got %b exp 0010", gnt);
        end
        tick();
        #2;
        rst = 1'b0;
        #1;
        checks++;
        if ({rsp_valid, busy, gnt} !== 9'b0) begin
            failures++;
            $display("FAIL rstmid_assert got rsp=%b busy=%b gnt=%b exp 0", rsp_valid, busy, gnt);
        end
        tick();
        @(negedge clk);
        checks++;
        if ({rsp_valid, busy} !== 5'b0) begin
            failures++;
            $display("FAIL rstmid_no_rsp got rsp=%b busy=%b exp 0", rsp_valid, busy);
        end
        rst = 1'b1;
        req = 4'b1111;
        tick();
        @(negedge clk);
        checks++;
        if ({gnt, rsp_valid} !== 8'b0001_0000) begin
            failures++;
            $display("FAIL rstmid_first_gnt got gnt=%b rsp=%b exp 0001 0000", gnt, rsp_valid);
        end
        req = 4'b0000;
        tick();
        tick();
        tick();
    endtask

`ifdef DFF_ARB_LOCK_EN
    task automatic test_lock();
        do_reset();
        for (int c = 0; c < 12; c++) begin
            req  = 4'b0011;
            lock = (c <= 7) ? 4'b0001 : 4'b0000;
            @(negedge clk);
            if (c == 1 || c == 4 || c == 7) begin
                checks++;
                if (gnt !== 4'b0001) begin
                    failures++;
                    $display("FAIL lock_hold cyc=%0d got %b exp 0001", c, gnt);
                end
            end else if (c == 10) begin
                checks++;
                if (gnt !== 4'b0010) begin
                    failures++;
                    $display("FAIL lock_release got %b exp 0010", gnt);
                end
            end
            tick();
        end
        req  = 4'b0000;
        tick();
        tick();
    endtask
`endif

    task automatic test_random();
        logic [3:0] exp_gnt  [0:NARR-1];
        logic [3:0] exp_rsp  [0:NARR-1];
        logic       exp_busy [0:NARR-1];
        logic       exp_d    [0:NARR-1];
        logic       exp_q    [0:NARR-1];
        int   m_ptr;
        int   m_free;
        int   w;
        logic m_dffd;
        logic m_rspq;
        do_reset();
        for (int i = 0; i < NARR; i++) begin
            exp_gnt[i]  = 4'b0000;
            exp_rsp[i]  = 4'b0000;
            exp_busy[i] = 1'b0;
            exp_d[i]    = 1'b0;
            exp_q[i]    = 1'b0;
        end
        m_ptr  = 0;
        m_free = 0;
        m_dffd = 1'b0;
        m_rspq = 1'b0;
        for (int c = 0; c < NCYC; c++) begin
            if (c < NCYC - 4 && $urandom_range(0, 3) != 0) req = 4'($urandom_range(0, 15));
            else req = 4'b0000;
            wdata = 4'($urandom_range(0, 15));
            // Arbiter is free to pick a winner whenever no transaction occupies this cycle.
            if (c >= m_free) begin
                if (req != 4'b0000) begin
                    w = -1;
                    for (int i = 0; i < NREQ; i++) begin
                        if (w < 0 && req[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
                    end
                    exp_gnt[c+1]  = 4'b0001 << w;
                    exp_d[c+1]    = wdata[w];
                    exp_rsp[c+3]  = 4'b0001 << w;
                    exp_q[c+3]    = wdata[w];
                    exp_busy[c+1] = 1'b1;
                    exp_busy[c+2] = 1'b1;
                    exp_busy[c+3] = 1'b1;
                    m_ptr  = (w + 1) % NREQ;
                    m_free = c + 3;
                end else begin
                    m_free = c + 1;
                end
            end
            @(negedge clk);
            if (exp_gnt[c] != 4'b0000) m_dffd = exp_d[c];
            if (exp_rsp[c] != 4'b0000) m_rspq = exp_q[c];
            checks++;
            if (gnt !== exp_gnt[c] || dff_en !== (exp_gnt[c] != 4'b0000)) begin
                failures++;
                $display("FAIL rand_gnt cyc=%0d got gnt=%b en=%b exp gnt=%b", c, gnt, dff_en, exp_gnt[c]);
            end
            checks++;
            if (rsp_valid !== exp_rsp[c]) begin
                failures++;
                $display("FAIL rand_rsp cyc=%0d got %b exp %b", c, rsp_valid, exp_rsp[c]);
            end
            checks++;
            if (busy !== exp_busy[c]) begin
                failures++;
                $display("FAIL rand_busy cyc=%0d got %b exp %b", c, busy, exp_busy[c]);
            end
            checks++;
            if (dff_d !== m_dffd || rsp_q !== m_rspq) begin
                failures++;
                $display("FAIL rand_data cyc=%0d got d=%b q=%b exp d=%b q=%b", c, dff_d, rsp_q, m_dffd, m_rspq);
            end
            tick();
        end
    endtask

    initial begin
        do_reset();
        test_reset();
        test_single();
        test_fairness();
        test_wrap();
        test_reset_mid();
`ifdef DFF_ARB_LOCK_EN
        test_lock();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
